// File: rtl/way_age_tracker.sv
// Per-set, per-way valid and age bookkeeping for the set-associative cache.
// Age 0 is the most recently used way. Ages saturate and never wrap.
// The lookup port returns a registered view of one set. A sequential flush
// clears one set per cycle.
module way_age_tracker #(
  parameter int unsigned N_WAYS   = 2,
  parameter int unsigned N_POW    = 4,
  parameter int unsigned N_SETS   = 16,
  parameter int unsigned SET_BITS = 4,
  parameter int unsigned AGE_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lookup_valid,
  input  logic [SET_BITS-1:0] lookup_set,
  output logic                line_empty [N_WAYS],
  output logic [31:0]         line_age   [N_WAYS],
  output logic                lookup_done,
  input  logic                access_valid,
  input  logic [SET_BITS-1:0] access_set,
  input  logic [N_POW-1:0]    access_way,
  input  logic                access_fill,
  input  logic                inval_valid,
  input  logic [SET_BITS-1:0] inval_set,
  input  logic [N_POW-1:0]    inval_way,
  input  logic                flush_req,
  output logic                busy,
  output logic                flush_done
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t              state, state_nxt;
  logic [SET_BITS-1:0] flush_set;
  logic                last_set;
  logic                tgt_ok;

  logic                valid_q [N_SETS][N_WAYS];
  logic                valid_d [N_SETS][N_WAYS];
  logic [AGE_W-1:0]    age_q   [N_SETS][N_WAYS];
  logic [AGE_W-1:0]    age_d   [N_SETS][N_WAYS];

  assign last_set = (flush_set == SET_BITS'(N_SETS - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: a flush walks every set once, then returns to idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (flush_req) state_nxt = S_FLUSH;
      S_FLUSH: if (last_set)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state == S_FLUSH);
    flush_done = (state == S_FLUSH) && last_set;
  end

  // Flush set pointer, held at zero outside a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 flush_set <= '0;
    else if (state == S_FLUSH)  flush_set <= last_set ? '0 : flush_set + SET_BITS'(1);
    else                        flush_set <= '0;
  end

  // Next array state. Invalidate is applied after the access, so it wins
  // on a same-way collision while the other ways keep the access ageing.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    tgt_ok  = 1'b0;
    for (int unsigned s = 0; s < N_SETS; s++) begin
      tgt_ok = 1'b0;
      for (int unsigned w = 0; w < N_WAYS; w++)
        if (access_way == N_POW'(w)) tgt_ok = access_fill || valid_q[s][w];
      if (!busy && access_valid && access_set == SET_BITS'(s) && tgt_ok) begin
        for (int unsigned w = 0; w < N_WAYS; w++) begin
          if (access_way == N_POW'(w)) begin
            age_d[s][w] = '0;
            if (access_fill) valid_d[s][w] = 1'b1;
          end else if (valid_q[s][w] && age_q[s][w] != '1) begin
            age_d[s][w] = age_q[s][w] + AGE_W'(1);
          end
        end
      end
      for (int unsigned w = 0; w < N_WAYS; w++) begin
        if (!busy && inval_valid && inval_set == SET_BITS'(s) && inval_way == N_POW'(w)) begin
          valid_d[s][w] = 1'b0;
          age_d[s][w]   = '0;
        end
        if (busy && flush_set == SET_BITS'(s)) begin
          valid_d[s][w] = 1'b0;
          age_d[s][w]   = '0;
        end
      end
    end
  end

  // Array state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < N_SETS; s++)
        for (int unsigned w = 0; w < N_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= '0;
        end
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Lookup outputs read the next-state view so same-cycle updates are visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_done <= 1'b0;
      for (int unsigned w = 0; w < N_WAYS; w++) begin
        line_empty[w] <= 1'b1;
        line_age[w]   <= '0;
      end
    end else begin
      lookup_done <= lookup_valid;
      if (lookup_valid) begin
        for (int unsigned s = 0; s < N_SETS; s++)
          if (lookup_set == SET_BITS'(s))
            for (int unsigned w = 0; w < N_WAYS; w++) begin
              line_empty[w] <= !valid_d[s][w];
              line_age[w]   <= 32'(age_d[s][w]);
            end
      end
    end
  end

endmodule

// File: tb/tb_way_age_tracker.sv
// Directed bench for way_age_tracker. Two instances share the stimulus:
// the default AGE_W=8 and an AGE_W=2 copy for saturation.
module tb_way_age_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [3:0]  lookup_set = '0;
  logic        access_valid = 1'b0;
  logic [3:0]  access_set = '0;
  logic [3:0]  access_way = '0;
  logic        access_fill = 1'b0;
  logic        inval_valid = 1'b0;
  logic [3:0]  inval_set = '0;
  logic [3:0]  inval_way = '0;
  logic        flush_req = 1'b0;

  logic        le  [2];
  logic [31:0] la  [2];
  logic        ld, busy, fd;
  logic        le2 [2];
  logic [31:0] la2 [2];
  logic        ld2, busy2, fd2;

  typedef struct {
    logic [1:0]  empty;
    logic [31:0] a0, a1, b0, b1;
  } exp_t;

  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;
  int   cycles, dones, done_at;

  always #5 clk = ~clk;

  way_age_tracker u_dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_set(lookup_set),
    .line_empty(le), .line_age(la), .lookup_done(ld),
    .access_valid(access_valid), .access_set(access_set),
    .access_way(access_way), .access_fill(access_fill),
    .inval_valid(inval_valid), .inval_set(inval_set), .inval_way(inval_way),
    .flush_req(flush_req), .busy(busy), .flush_done(fd)
  );

  way_age_tracker #(.AGE_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_set(lookup_set),
    .line_empty(le2), .line_age(la2), .lookup_done(ld2),
    .access_valid(access_valid), .access_set(access_set),
    .access_way(access_way), .access_fill(access_fill),
    .inval_valid(inval_valid), .inval_set(inval_set), .inval_way(inval_way),
    .flush_req(flush_req), .busy(busy2), .flush_done(fd2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mk(input logic [1:0] e, input int a0, input int a1,
                    input int b0, input int b1);
    exp_t x;
    x.empty = e; x.a0 = a0; x.a1 = a1; x.b0 = b0; x.b1 = b1;
    sb.push_back(x);
  endtask

  // Compare both instances against the oldest queued expectation
  task automatic check_out(input string tag);
    exp_t x;
    chk({tag, ".done"},  {31'b0, ld},  32'd1);
    chk({tag, ".done2"}, {31'b0, ld2}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, ".sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, ".empty"},  {30'b0, le[1], le[0]},   {30'b0, x.empty});
      chk({tag, ".empty2"}, {30'b0, le2[1], le2[0]}, {30'b0, x.empty});
      chk({tag, ".age0"},  la[0],  x.a0);
      chk({tag, ".age1"},  la[1],  x.a1);
      chk({tag, ".age0_w2"}, la2[0], x.b0);
      chk({tag, ".age1_w2"}, la2[1], x.b1);
    end
  endtask

  task automatic acc(input int s, input int w, input logic fill);
    access_valid = 1'b1; access_set = 4'(s); access_way = 4'(w); access_fill = fill;
    tick();
    access_valid = 1'b0;
  endtask

  task automatic inv(input int s, input int w);
    inval_valid = 1'b1; inval_set = 4'(s); inval_way = 4'(w);
    tick();
    inval_valid = 1'b0;
  endtask

  task automatic look(input string tag, input int s);
    lookup_valid = 1'b1; lookup_set = 4'(s);
    tick();
    lookup_valid = 1'b0;
    check_out(tag);
  endtask

  initial begin
    // reset values while reset is held
    #12;
    chk("rst.empty", {30'b0, le[1], le[0]}, 32'd3);
    chk("rst.age0", la[0], 32'd0);
    chk("rst.age1", la[1], 32'd0);
    chk("rst.done", {31'b0, ld}, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.flush_done", {31'b0, fd}, 32'd0);
    rst_n = 1'b1;
    tick();

    mk(2'b11, 0, 0, 0, 0); look("lk_s3", 3);
    tick();
    chk("done_pulse_ends", {31'b0, ld}, 32'd0);

    acc(5, 0, 1'b1); acc(5, 1, 1'b1);
    mk(2'b00, 1, 0, 1, 0); look("fill_s5", 5);
    acc(5, 0, 1'b0);
    mk(2'b00, 0, 1, 0, 1); look("hit_s5w0", 5);

    // access and lookup in the same cycle: bypass
    access_valid = 1'b1; access_set = 4'd5; access_way = 4'd1; access_fill = 1'b0;
    mk(2'b00, 1, 0, 1, 0); look("bypass_s5", 5);
    access_valid = 1'b0;

    // saturation: w0 ages 5 times, AGE_W=2 copy stops at 3
    acc(7, 0, 1'b1); acc(7, 1, 1'b1);
    for (int i = 0; i < 4; i++) acc(7, 1, 1'b0);
    mk(2'b00, 5, 0, 3, 0); look("sat_s7", 7);

    // hit to an invalid way changes nothing
    acc(10, 0, 1'b1); acc(10, 1, 1'b0);
    mk(2'b10, 0, 0, 0, 0); look("hit_invalid_s10", 10);

    // same-cycle hit and invalidate on one way
    acc(2, 1, 1'b1); acc(2, 0, 1'b1);
    access_valid = 1'b1; access_set = 4'd2; access_way = 4'd1; access_fill = 1'b0;
    inv(2, 1);
    access_valid = 1'b0;
    mk(2'b10, 1, 0, 1, 0); look("hit_inval_s2", 2);

    // out-of-range way indices are ignored
    acc(5, 2, 1'b1); inv(5, 3);
    mk(2'b00, 1, 0, 1, 0); look("oob_way_s5", 5);

    // fill and invalidate in different sets in one cycle
    access_valid = 1'b1; access_set = 4'd11; access_way = 4'd0; access_fill = 1'b1;
    inv(5, 0);
    access_valid = 1'b0;
    mk(2'b01, 0, 0, 0, 0); look("inval_s5w0", 5);
    mk(2'b10, 0, 0, 0, 0); look("fill_s11", 11);

    // full flush, with a dropped access and an accepted lookup while busy
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    cycles = 0; dones = 0; done_at = 0;
    while (busy && cycles < 40) begin
      cycles++;
      if (fd) begin dones++; done_at = cycles; end
      access_valid = (cycles == 3); access_set = 4'd12; access_way = 4'd0; access_fill = 1'b1;
      lookup_valid = (cycles == 2); lookup_set = 4'd7;
      if (cycles == 2) mk(2'b00, 5, 0, 3, 0);
      tick();
      if (cycles == 2) check_out("lk_during_flush");
    end
    access_valid = 1'b0; lookup_valid = 1'b0;
    chk("flush.cycles", cycles, 32'd16);
    chk("flush.done_count", dones, 32'd1);
    chk("flush.done_at", done_at, 32'd16);
    chk("flush.busy_after", {31'b0, busy}, 32'd0);
    chk("flush.busy2_after", {31'b0, busy2}, 32'd0);
    mk(2'b11, 0, 0, 0, 0); look("post_flush_s5", 5);
    mk(2'b11, 0, 0, 0, 0); look("post_flush_s7", 7);
    mk(2'b11, 0, 0, 0, 0); look("dropped_fill_s12", 12);

    // reset during flush cycle 5 aborts the flush at once
    acc(6, 0, 1'b1);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    repeat (4) tick();
    chk("flush2.busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", {31'b0, busy}, 32'd0);
    chk("midrst.flush_done", {31'b0, fd}, 32'd0);
    chk("midrst.empty", {30'b0, le[1], le[0]}, 32'd3);
    #5 rst_n = 1'b1;
    tick();
    chk("midrst.busy_after", {31'b0, busy}, 32'd0);
    mk(2'b11, 0, 0, 0, 0); look("midrst_s6", 6);
    acc(6, 1, 1'b1);
    mk(2'b01, 0, 0, 0, 0); look("refill_s6", 6);

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
